ss_tbl_mngr: RTL and testbench

- Parametrised successor to the single-entry slave-select manager.
- Tracks up to NSLOT concurrently open slave-select IDs in a small table.
- Each entry has a per-slot idle timeout; one entry is the "active" select presented downstream.
- Sits between the L3 header decoder (supplies l3_id, set/clr/activity strobes) and the SPI slave-select driver.

---
 rtl/ss_tbl_mngr.sv | 219 +++++++++++++++++++++
 tb/tb_ss_tbl_mngr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_tbl_mngr.sv
// ss_tbl_mngr : slave-select table manager.
// Holds up to NSLOT open slave-select IDs, each with its own idle timer.
// One entry is the "active" select presented to the SPI slave-select driver.
//
// Optional feature macro: SS_TBL_LRU_EVICT_EN
//   defined   : ss_set that misses on a full table evicts the entry with the
//               largest idle counter (ties -> lowest index) instead of
//               rejecting with ovf.
//   undefined : full-table miss is rejected with an ovf pulse.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_mk         flush the whole table
//   ss_set         open/refresh l3_id and make it active
//   ss_clr         close the entry matching l3_id
//   act            activity strobe, refreshes the timer of the matching entry
//   l3_id          ID under decode (upper bits above SS_W must be zero)
//   tmo_lim        idle limit in cycles, 0 disables timeout
//   ssid/ssid_vld  active entry ID and valid flag
//   slot_vld/full  per-entry valid bits, all-valid flag
//   err_id         combinational: l3_id malformed or not open
//   ovf            one-cycle pulse, ss_set rejected
//   tmo_evt        one-cycle pulse, an entry expired
//   tmo_slot       lowest expired entry index, held until the next tmo_evt
module ss_tbl_mngr #(
    parameter int ID_W  = 4,
    parameter int SS_W  = 3,
    parameter int NSLOT = 4,
    parameter int TMO_W = 8,
    localparam int PTR_W = $clog2(NSLOT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_mk,
    input  logic             ss_set,
    input  logic             ss_clr,
    input  logic             act,
    input  logic [ID_W-1:0]  l3_id,
    input  logic [TMO_W-1:0] tmo_lim,
    output logic [SS_W-1:0]  ssid,
    output logic             ssid_vld,
    output logic [NSLOT-1:0] slot_vld,
    output logic             full,
    output logic             err_id,
    output logic             ovf,
    output logic             tmo_evt,
    output logic [PTR_W-1:0] tmo_slot
);

    logic [NSLOT-1:0]            vld_q, vld_d;
    logic [NSLOT-1:0][SS_W-1:0]  id_q, id_d;
    logic [NSLOT-1:0][TMO_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic                        ovf_q, ovf_d;
    logic                        evt_q, evt_d;
    logic [PTR_W-1:0]            tslot_q, tslot_d;

    logic                        id_ok_s;
    logic [NSLOT-1:0]            hit_vec_s;
    logic                        hit_s;
    logic [PTR_W-1:0]            hit_idx_s;
    logic [PTR_W-1:0]            free_idx_s;
    logic [NSLOT-1:0]            refresh_s;
    logic [NSLOT-1:0]            expire_s;
`ifdef SS_TBL_LRU_EVICT_EN
    logic [PTR_W-1:0]            victim_idx_s;
    logic [TMO_W-1:0]            victim_cnt_s;
`endif

    // Table lookup: match, lowest free slot; descending loop so lowest index wins.
    always_comb begin
        id_ok_s    = (l3_id[ID_W-1:SS_W] == '0);
        hit_vec_s  = '0;
        hit_idx_s  = '0;
        free_idx_s = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            hit_vec_s[i] = vld_q[i] && (id_q[i] == l3_id[SS_W-1:0]);
            if (hit_vec_s[i]) begin
                hit_idx_s = PTR_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
            if (!vld_q[i]) begin
                free_idx_s = PTR_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        // A malformed ID can never match, even if its low bits do.
        hit_s = id_ok_s && (|hit_vec_s);
    end

`ifdef SS_TBL_LRU_EVICT_EN
    // Eviction victim: largest idle counter; strict compare keeps the lowest index on ties.
    always_comb begin
        victim_idx_s = '0;
        victim_cnt_s = cnt_q[0];
        for (int i = 1; i < NSLOT; i++) begin
            if (cnt_q[i] > victim_cnt_s) begin
                victim_cnt_s = cnt_q[i];
                victim_idx_s = PTR_W'(i);
            end else begin
                victim_cnt_s = victim_cnt_s;
            end
        end
    end
`endif

    // Next-state: prioritised commands, then idle timers on untouched valid slots.
    always_comb begin
        vld_d     = vld_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ovf_d     = 1'b0;
        evt_d     = 1'b0;
        tslot_d   = tslot_q;
        refresh_s = '0;
        expire_s  = '0;
        if (clr_mk) begin
            vld_d = '0;
            cnt_d = '0;
            ptr_d = '0;
        end else begin
            if (ss_clr) begin
                if (hit_s) begin
                    vld_d[hit_idx_s] = 1'b0;
                    cnt_d[hit_idx_s] = '0;
                end else begin
                    vld_d = vld_q;
                end
            end else if (ss_set) begin
                if (!id_ok_s) begin
                    ovf_d = 1'b1;
                end else if (hit_s) begin
                    ptr_d                = hit_idx_s;
                    refresh_s[hit_idx_s] = 1'b1;
                end else if (!(&vld_q)) begin
                    vld_d[free_idx_s]     = 1'b1;
                    id_d[free_idx_s]      = l3_id[SS_W-1:0];
                    ptr_d                 = free_idx_s;
                    refresh_s[free_idx_s] = 1'b1;
                end else begin
`ifdef SS_TBL_LRU_EVICT_EN
                    id_d[victim_idx_s]      = l3_id[SS_W-1:0];
                    ptr_d                   = victim_idx_s;
                    refresh_s[victim_idx_s] = 1'b1;
`else
                    ovf_d = 1'b1;
`endif
                end
            end else if (act && hit_s) begin
                refresh_s[hit_idx_s] = 1'b1;
            end else begin
                ovf_d = 1'b0;
            end

            // Slots closed this cycle have vld_d low and are skipped; refresh beats expiry.
            for (int i = 0; i < NSLOT; i++) begin
                if (refresh_s[i]) begin
                    cnt_d[i] = '0;
                end else if (vld_q[i] && vld_d[i]) begin
                    if (tmo_lim == '0) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] >= (tmo_lim - TMO_W'(1))) begin
                        // >= also catches a limit lowered below a running counter.
                        vld_d[i]    = 1'b0;
                        cnt_d[i]    = '0;
                        expire_s[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + TMO_W'(1);
                    end
                end else begin
                    cnt_d[i] = cnt_d[i];
                end
            end

            for (int i = NSLOT - 1; i >= 0; i--) begin
                if (expire_s[i]) begin
                    evt_d   = 1'b1;
                    tslot_d = PTR_W'(i);
                end else begin
                    evt_d = evt_d;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            evt_q   <= 1'b0;
            tslot_q <= '0;
        end else begin
            vld_q   <= vld_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            evt_q   <= evt_d;
            tslot_q <= tslot_d;
        end
    end

    assign slot_vld = vld_q;
    assign full     = &vld_q;
    assign ssid_vld = vld_q[ptr_q];
    assign ssid     = vld_q[ptr_q] ? id_q[ptr_q] : '0;
    assign err_id   = !hit_s;
    assign ovf      = ovf_q;
    assign tmo_evt  = evt_q;
    assign tmo_slot = tslot_q;

endmodule

// File: tb/tb_ss_tbl_mngr.sv
module tb_ss_tbl_mngr;

    localparam int ID_W  = 4;
    localparam int SS_W  = 3;
    localparam int NS    = 4;
    localparam int TMO_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_mk, ss_set, ss_clr, act;
    logic [ID_W-1:0]  l3_id;
    logic [TMO_W-1:0] tmo_lim;
    logic [SS_W-1:0]  ssid;
    logic             ssid_vld;
    logic [NS-1:0]    slot_vld;
    logic             full, err_id, ovf, tmo_evt;
    logic [1:0]       tmo_slot;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: table of open IDs with idle ages, expressed as plain ints.
    bit [NS-1:0] m_vld;
    int          m_id  [NS];
    int          m_age [NS];
    int          m_act;
    bit          m_ovf, m_evt;
    int          m_tslot;

    always #5 clk = ~clk;

    ss_tbl_mngr #(.ID_W(ID_W), .SS_W(SS_W), .NSLOT(NS), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .clr_mk(clr_mk), .ss_set(ss_set), .ss_clr(ss_clr),
        .act(act), .l3_id(l3_id), .tmo_lim(tmo_lim), .ssid(ssid), .ssid_vld(ssid_vld),
        .slot_vld(slot_vld), .full(full), .err_id(err_id), .ovf(ovf),
        .tmo_evt(tmo_evt), .tmo_slot(tmo_slot)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = '0;
        for (int i = 0; i < NS; i++) begin
            m_id[i]  = 0;
            m_age[i] = 0;
        end
        m_act = 0; m_ovf = 0; m_evt = 0; m_tslot = 0;
    endtask

    // l3_id values >= 2**SS_W can never equal a stored ID, so no separate id check is needed.
    function automatic int model_find();
        for (int i = 0; i < NS; i++)
            if (m_vld[i] && m_id[i] == int'(l3_id)) return i;
        return -1;
    endfunction

    task automatic model_step();
        int h, fs;
        bit [NS-1:0] refr;
        h = model_find();
        m_ovf = 0; m_evt = 0; refr = '0;
        if (clr_mk) begin
            m_vld = '0;
            for (int i = 0; i < NS; i++) m_age[i] = 0;
            m_act = 0;
            return;
        end
        if (ss_clr) begin
            if (h >= 0) begin m_vld[h] = 0; m_age[h] = 0; end
        end else if (ss_set) begin
            if (int'(l3_id) >= (1 << SS_W)) m_ovf = 1;
            else if (h >= 0) begin refr[h] = 1; m_act = h; end
            else begin
                fs = -1;
                for (int i = NS - 1; i >= 0; i--) if (!m_vld[i]) fs = i;
                if (fs >= 0) begin
                    m_vld[fs] = 1; m_id[fs] = int'(l3_id); refr[fs] = 1; m_act = fs;
                end else begin
`ifdef SS_TBL_LRU_EVICT_EN
                    fs = 0;
                    for (int i = 1; i < NS; i++) if (m_age[i] > m_age[fs]) fs = i;
                    m_id[fs] = int'(l3_id); refr[fs] = 1; m_act = fs;
`else
                    m_ovf = 1;
`endif
                end
            end
        end else if (act && h >= 0) begin
            refr[h] = 1;
        end
        for (int i = 0; i < NS; i++) begin
            if (refr[i]) m_age[i] = 0;
            else if (m_vld[i] && tmo_lim != 0) begin
                if (m_age[i] + 1 >= int'(tmo_lim)) begin
                    m_vld[i] = 0; m_age[i] = 0;
                    if (!m_evt) begin m_evt = 1; m_tslot = i; end
                end else m_age[i] = m_age[i] + 1;
            end else if (m_vld[i]) m_age[i] = 0;
        end
    endtask

    task automatic chk_outputs();
        int e_ssid;
        e_ssid = m_vld[m_act] ? m_id[m_act] : 0;
        chk("ssid",     32'(ssid),     32'(e_ssid));
        chk("ssid_vld", 32'(ssid_vld), 32'(m_vld[m_act]));
        chk("slot_vld", 32'(slot_vld), 32'(m_vld));
        chk("full",     32'(full),     32'(&m_vld));
        chk("ovf",      32'(ovf),      32'(m_ovf));
        chk("tmo_evt",  32'(tmo_evt),  32'(m_evt));
        chk("tmo_slot", 32'(tmo_slot), 32'(m_tslot));
    endtask

    // One clock: drive, check combinational err_id, clock, advance model, check registered outputs.
    task automatic step(bit c, bit s, bit k, bit a, int id);
        clr_mk = c; ss_set = s; ss_clr = k; act = a; l3_id = ID_W'(id);
        #1;
        chk("err_id", 32'(err_id), (model_find() >= 0) ? 32'd0 : 32'd1);
        @(posedge clk);
        model_step();
        #1;
        chk_outputs();
    endtask

    initial begin
        rst = 1'b1; clr_mk = 1'b0; ss_set = 1'b0; ss_clr = 1'b0; act = 1'b0;
        l3_id = '0; tmo_lim = '0;
        model_reset();
        #1;
        chk("rst_ssid",     32'(ssid),     32'd0);
        chk("rst_ssid_vld", 32'(ssid_vld), 32'd0);
        chk("rst_slot_vld", 32'(slot_vld), 32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_ovf",      32'(ovf),      32'd0);
        chk("rst_tmo_evt",  32'(tmo_evt),  32'd0);
        chk("rst_tmo_slot", 32'(tmo_slot), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // First open
        step(0, 1, 0, 0, 5);
        chk("set5_ssid",     32'(ssid),     32'd5);
        chk("set5_ssid_vld", 32'(ssid_vld), 32'd1);
        chk("set5_slot_vld", 32'(slot_vld), 32'b0001);
        step(0, 0, 0, 0, 5);
        l3_id = 4'd6; #1;
        chk("err_id_miss", 32'(err_id), 32'd1);

        // Fill the table, then one more
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, i);
        step(0, 1, 0, 0, 5);
        chk("full_after5", 32'(full),     32'd1);
        chk("slots_after5", 32'(slot_vld), 32'b1111);
`ifdef SS_TBL_LRU_EVICT_EN
        chk("lru_ovf",  32'(ovf),  32'd0);
        chk("lru_ssid", 32'(ssid), 32'd5);
`else
        chk("full_ovf",  32'(ovf),  32'd1);
        chk("full_ssid", 32'(ssid), 32'd4);
`endif
        step(0, 0, 0, 0, 0);

        // Malformed ID
        step(0, 1, 0, 0, 9);
        chk("bad_id_ovf", 32'(ovf), 32'd1);
        #1;
        chk("bad_id_err", 32'(err_id), 32'd1);
        step(0, 0, 0, 0, 9);

        // Timeout after exactly tmo_lim idle cycles
        step(1, 0, 0, 0, 0);
        tmo_lim = 8'd5;
        step(0, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2);
        chk("tmo_alive", 32'(slot_vld), 32'b0001);
        step(0, 0, 0, 0, 2);
        chk("tmo_evt_fire", 32'(tmo_evt),  32'd1);
        chk("tmo_slot0",    32'(tmo_slot), 32'd0);
        chk("tmo_gone",     32'(slot_vld), 32'b0000);
        chk("tmo_ssid_vld", 32'(ssid_vld), 32'd0);
        step(0, 0, 0, 0, 2);

        // Periodic activity keeps the slot alive
        step(0, 1, 0, 0, 2);
        for (int j = 0; j < 20; j++) step(0, 0, 0, (j % 3) == 2, 2);
        chk("act_keeps", 32'(slot_vld), 32'b0001);

        // Priority: ss_clr beats ss_set, clr_mk beats ss_set
        tmo_lim = 8'd0;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 3);
        step(0, 1, 1, 0, 3);
        chk("clr_over_set", 32'(slot_vld), 32'b0000);
        step(0, 1, 0, 0, 3);
        step(0, 1, 0, 0, 4);
        step(1, 1, 0, 0, 6);
        chk("clrmk_over_set", 32'(slot_vld), 32'b0000);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) begin
                case ($urandom_range(0, 4))
                    0: tmo_lim = 8'd0;
                    1: tmo_lim = 8'd2;
                    2: tmo_lim = 8'd4;
                    3: tmo_lim = 8'd9;
                    default: tmo_lim = 8'd30;
                endcase
            end
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 40,
                 int'($urandom_range(0, 9)));
        end

        // Asynchronous reset mid-operation
        tmo_lim = 8'd10;
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, i);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ssid",     32'(ssid),     32'd0);
        chk("arst_ssid_vld", 32'(ssid_vld), 32'd0);
        chk("arst_slot_vld", 32'(slot_vld), 32'd0);
        chk("arst_full",     32'(full),     32'd0);
        chk("arst_ovf",      32'(ovf),      32'd0);
        chk("arst_tmo_evt",  32'(tmo_evt),  32'd0);
        chk("arst_tmo_slot", 32'(tmo_slot), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 1, 0, 0, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
